aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
- Iterative sequencer for the AES-128 encryption round datapath: a 2-stage registered round function (SubBytes/ShiftRows, then MixColumns/AddRoundKey).
- Accepts one plaintext block per valid/ready handshake and performs the initial AddRoundKey itself.
- Loops the block through the round datapath NR times, driving the round-key index and the final-round flag.
- Returns the ciphertext on a valid/ready output handshake. One block in flight at a time.

Parameters:
- NR, 10, number of AES rounds; round-key indices run 0..NR.
- ROUND_LAT, 2, register latency of the round datapath, from oRoundIn stable to iRoundOut valid.
- KIDX_W, 4, width of the round-key index; must satisfy 2^KIDX_W > NR.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- iValid  in  1  input block valid.
- oReady  out  1  controller can accept a block (state IDLE).
- iBlockIn  in  128  plaintext block.
- oKeyIdx  out  KIDX_W  round-key index to the key store.
- iKeyValue  in  128  round key for oKeyIdx, combinational from the key store, same cycle.
- oRoundIn  out  128  state presented to the round datapath.
- oFinal  out  1  final round: the datapath skips MixColumns.
- iRoundOut  in  128  round datapath output.
- oValid  out  1  ciphertext valid.
- iReady  in  1  downstream accepts the ciphertext.
- oBlockOut  out  128  ciphertext.
- oBusy  out  1  high when the state is not IDLE.

Behaviour:
- Reset values:
  - state IDLE; oReady=1; oValid=0; oBusy=0; oFinal=0.
  - oKeyIdx=0; rRound=0; rCnt=0; rState=0, so oRoundIn=0 and oBlockOut=0.
- Reset mid-operation abandons the block (no output) and returns to IDLE on the next cycle.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - oKeyIdx=0, oReady=1.
  - On iValid&oReady: rState<=iBlockIn^iKeyValue; rRound<=1; rCnt<=0; go to ROUND.
- ROUND:
  - oRoundIn=rState and oKeyIdx=rRound, both held constant for the whole round. This keeps the key stable when stage 2 samples it.
  - oFinal=(rRound==NR).
  - rCnt counts 0..ROUND_LAT. Each round is ROUND_LAT+1 cycles.
  - At rCnt==ROUND_LAT: rState<=iRoundOut, rCnt<=0.
    - If rRound==NR, go to DONE.
    - Otherwise rRound<=rRound+1.
- DONE:
  - oValid=1, oBlockOut=rState.
  - Hold oBlockOut stable until iReady. On oValid&iReady go to IDLE.
  - No new block is accepted in the same cycle: oReady=0 in DONE.
- Latency: handshake at cycle 0 → oValid first high at cycle 1+NR*(ROUND_LAT+1), which is cycle 31 with defaults.
- Throughput: at most one block per 32 cycles with defaults when iReady is held high.
- In IDLE, iValid without a handshake has no effect.
- iReady outside DONE is ignored.
- In ROUND and DONE, iBlockIn and iValid are ignored (oReady=0).
- The datapath is free-running. Only the sample at rCnt==ROUND_LAT is used; intermediate iRoundOut values are don't-care.
- All outputs are registered or decoded from registered state only. There is no combinational path from iValid or iReady to any output.
- The datapath's final-round MixColumns bypass is controlled solely by oFinal.

Decomposition:
- Shared package aes_pkg holds:
  - localparams AES_NR=10, AES_BLOCK_W=128, AES_KIDX_W=4.
  - an enum for the FSM states IDLE/ROUND/DONE.
- No sub-module. The round counter and the cycle counter stay inline in aes_round_ctrl.
- Top-level integration instantiates aes_round_ctrl, the round datapath, and the key store as siblings.

Test Plan:
- FIPS-197 C.1 vector, bench supplying the expanded keys and the real datapath:
  - key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff, iReady=1.
  - → oValid at cycle 31; oBlockOut = 69c4e0d86a7b0430d8cdb78070b4c55a.
  - → oReady returns to 1 at cycle 32.
- Sequence check, same vector:
  - → oKeyIdx steps 0,1,...,10, each value held 3 cycles after the accept.
  - → oFinal high only for cycles 28-30; oBusy high for cycles 1-31.
- Backpressure: iReady=0 for 10 cycles after oValid rises.
  - → oBlockOut is constant and oValid stays high.
  - → returns to IDLE the cycle after iReady=1.
  - → iValid asserted during the stall is not accepted.
- Back-to-back: two blocks with iValid held high and iReady=1.
  - → second accept occurs at cycle 32.
  - → the second ciphertext is correct and independent of the first.
- Reset mid-operation: assert rst at cycle 12 for 1 cycle.
  - → no oValid appears; all outputs take their reset values.
  - → a new block accepted afterward produces the correct ciphertext at +31 cycles.
- Key-index alignment: the bench key store returns 0 for any index other than the expected one during stage-2 sampling.
  - → a correct ciphertext proves oKeyIdx is stable at every stage-2 sample.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 localparams and round controller state encoding
package aes_pkg;

  localparam int AES_NR      = 10;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_KIDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aesState_t;

endpackage

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES-128 encryption round sequencer
// Does the initial AddRoundKey, then loops the block NR times through an external round datapath.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR        = AES_NR,
  parameter int ROUND_LAT = 2,
  parameter int KIDX_W    = AES_KIDX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iValid,
  output logic                   oReady,
  input  logic [AES_BLOCK_W-1:0] iBlockIn,
  output logic [KIDX_W-1:0]      oKeyIdx,
  input  logic [AES_BLOCK_W-1:0] iKeyValue,
  output logic [AES_BLOCK_W-1:0] oRoundIn,
  output logic                   oFinal,
  input  logic [AES_BLOCK_W-1:0] iRoundOut,
  output logic                   oValid,
  input  logic                   iReady,
  output logic [AES_BLOCK_W-1:0] oBlockOut,
  output logic                   oBusy
);

  localparam int CNT_W = (ROUND_LAT < 1) ? 1 : $clog2(ROUND_LAT + 1);
  localparam logic [KIDX_W-1:0] LAST_ROUND = KIDX_W'(NR);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(ROUND_LAT);

  aesState_t              rFsm, nFsm;
  logic [AES_BLOCK_W-1:0] rState, nState;
  logic [KIDX_W-1:0]      rRound, nRound;
  logic [CNT_W-1:0]       rCnt, nCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rFsm   <= IDLE;
      rState <= '0;
      rRound <= '0;
      rCnt   <= '0;
    end else begin
      rFsm   <= nFsm;
      rState <= nState;
      rRound <= nRound;
      rCnt   <= nCnt;
    end
  end

  always_comb begin
    nFsm   = rFsm;
    nState = rState;
    nRound = rRound;
    nCnt   = rCnt;
    case (rFsm)
      IDLE: begin
        if (iValid) begin
          nState = iBlockIn ^ iKeyValue;
          nRound = KIDX_W'(1);
          nCnt   = '0;
          nFsm   = ROUND;
        end
      end
      ROUND: begin
        // Only the datapath sample at the last count is meaningful.
        if (rCnt == CNT_LAST) begin
          nState = iRoundOut;
          nCnt   = '0;
          if (rRound == LAST_ROUND) begin
            nFsm = DONE;
          end else begin
            nRound = rRound + KIDX_W'(1);
          end
        end else begin
          nCnt = rCnt + CNT_W'(1);
        end
      end
      DONE: begin
        if (iReady) begin
          nFsm = IDLE;
        end
      end
      default: nFsm = IDLE;
    endcase
  end

  // Key index stays at rRound for the whole round so stage 2 always sees the right key.
  assign oReady    = (rFsm == IDLE);
  assign oBusy     = (rFsm != IDLE);
  assign oValid    = (rFsm == DONE);
  assign oKeyIdx   = (rFsm == IDLE) ? '0 : rRound;
  assign oFinal    = (rFsm == ROUND) && (rRound == LAST_ROUND);
  assign oRoundIn  = rState;
  assign oBlockOut = rState;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - bench for aes_round_ctrl with AES-128 model, datapath and key store
module tb_aes_round_ctrl;

  localparam int NR  = 10;
  localparam int LAT = 2;
  localparam int RLEN = LAT + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         iValid;
  logic         oReady;
  logic [127:0] iBlockIn;
  logic [3:0]   oKeyIdx;
  logic [127:0] iKeyValue;
  logic [127:0] oRoundIn;
  logic         oFinal;
  logic [127:0] iRoundOut;
  logic         oValid;
  logic         iReady;
  logic [127:0] oBlockOut;
  logic         oBusy;

  int total = 0;
  int bad   = 0;

  aes_round_ctrl #(.NR(NR), .ROUND_LAT(LAT), .KIDX_W(4)) dut (
    .clk(clk), .rst(rst), .iValid(iValid), .oReady(oReady), .iBlockIn(iBlockIn),
    .oKeyIdx(oKeyIdx), .iKeyValue(iKeyValue), .oRoundIn(oRoundIn), .oFinal(oFinal),
    .iRoundOut(iRoundOut), .oValid(oValid), .iReady(iReady), .oBlockOut(oBlockOut),
    .oBusy(oBusy)
  );

  always #5 clk = ~clk;

  logic [7:0] sboxT [256];

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] subShift(logic [127:0] s);
    logic [127:0] o;
    int src;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      src = (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
      o[127-8*i -: 8] = sboxT[s[127-8*src -: 8]];
    end
    return o;
  endfunction

  function automatic logic [127:0] mixCols(logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [127:0] roundKey(logic [127:0] key, int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sboxT[t[31:24]], sboxT[t[23:16]], sboxT[t[15:8]], sboxT[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] aesEncrypt(logic [127:0] key, logic [127:0] pt);
    logic [127:0] st;
    st = pt ^ roundKey(key, 0);
    for (int r = 1; r <= NR; r++) begin
      st = subShift(st);
      if (r != NR) st = mixCols(st);
      st ^= roundKey(key, r);
    end
    return st;
  endfunction

  // Two-stage round datapath; the final-round bypass follows oFinal only.
  logic [127:0] s1 = '0;
  logic [127:0] s2 = '0;
  always @(posedge clk) begin
    s1 <= subShift(oRoundIn);
    s2 <= (oFinal ? s1 : mixCols(s1)) ^ iKeyValue;
  end
  assign iRoundOut = s2;

  // Strict key store: only the index due at this point of the schedule gets a real key.
  logic [127:0] rk [0:NR];
  int cyc = 0;
  int acceptCyc = -1000;
  int expIdx;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) acceptCyc <= -1000;
    else if (iValid && oReady) acceptCyc <= cyc;
  end
  always_comb begin
    int d;
    d = cyc - acceptCyc;
    expIdx = (d >= 1 && d <= NR * RLEN) ? (d + LAT) / RLEN : 0;
    iKeyValue = '0;
    if (int'(oKeyIdx) == expIdx && int'(oKeyIdx) <= NR) iKeyValue = rk[oKeyIdx];
  end

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;
  vec_t vecs [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic loadKey(input logic [127:0] key);
    for (int r = 0; r <= NR; r++) rk[r] = roundKey(key, r);
  endtask

  task automatic chkReset(input string tag);
    chk({tag, "_ready"}, oReady, 1);
    chk({tag, "_valid"}, oValid, 0);
    chk({tag, "_busy"}, oBusy, 0);
    chk({tag, "_final"}, oFinal, 0);
    chk({tag, "_keyidx"}, oKeyIdx, 0);
    chk({tag, "_roundin"}, oRoundIn, 0);
    chk({tag, "_blockout"}, oBlockOut, 0);
  endtask

  // Accept in the current cycle (cycle 0), then check every cycle up to the return to IDLE.
  task automatic runSeq(input logic [127:0] pt, input logic [127:0] ct);
    iBlockIn = pt;
    iValid = 1'b1;
    iReady = 1'b1;
    chk("seq_accept_ready", oReady, 1);
    tick();
    iValid = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      if (c != 31) chk($sformatf("seq_keyidx_c%0d", c), oKeyIdx, (c <= 30) ? (c + 2) / 3 : 0);
      chk($sformatf("seq_final_c%0d", c), oFinal, (c >= 28 && c <= 30));
      chk($sformatf("seq_busy_c%0d", c), oBusy, (c <= 31));
      chk($sformatf("seq_valid_c%0d", c), oValid, (c == 31));
      chk($sformatf("seq_ready_c%0d", c), oReady, (c == 32));
      if (c == 31) chk("seq_ct", oBlockOut, ct);
      if (c < 32) tick();
    end
  endtask

  task automatic runBlock(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] exp;
    int n;
    bit done;
    exp = aesEncrypt(key, pt);
    loadKey(key);
    iBlockIn = pt;
    iValid = 1'b1;
    iReady = 1'b0;
    chk("blk_ready", oReady, 1);
    tick();
    iValid = $urandom_range(0, 1);
    iBlockIn = {$urandom, $urandom, $urandom, $urandom};
    n = 1;
    while (!oValid && n < 100) begin
      iReady = $urandom_range(0, 1);
      tick();
      n++;
    end
    chk("blk_latency", n, 31);
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      iReady = (k == 39) || ($urandom_range(0, 2) == 0);
      chk("blk_valid", oValid, 1);
      chk("blk_ct", oBlockOut, exp);
      done = iReady;
      tick();
    end
    iValid = 1'b0;
    iReady = 1'b0;
    chk("blk_release", {oReady, oValid}, 2'b10);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] bB;
    logic [127:0] pR;
    bit sawValid;

    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv, b, s;
      inv = 8'h00;
      for (int j = 1; j < 256; j++) if (gmul(8'(v), 8'(j)) == 8'h01) inv = 8'(j);
      b = inv;
      s = inv;
      for (int k = 0; k < 4; k++) begin
        b = {b[6:0], b[7]};
        s ^= b;
      end
      sboxT[v] = s ^ 8'h63;
    end

    vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                pt:  128'h00112233445566778899aabbccddeeff,
                ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                pt:  128'h3243f6a8885a308d313198a2e0370734,
                ct:  128'h3925841d02dc09fbdc118597196a0b32};

    rst = 1'b1;
    iValid = 1'b0;
    iReady = 1'b0;
    iBlockIn = '0;
    loadKey(vecs[0].key);
    tick();
    tick();
    chkReset("rst");
    rst = 1'b0;
    tick();

    for (int v = 0; v < 2; v++) begin
      loadKey(vecs[v].key);
      runSeq(vecs[v].pt, vecs[v].ct);
    end

    // Backpressure with iValid asserted during the stall.
    loadKey(vecs[0].key);
    iBlockIn = vecs[0].pt;
    iValid = 1'b1;
    iReady = 1'b0;
    tick();
    iValid = 1'b0;
    repeat (30) tick();
    for (int s = 0; s < 10; s++) begin
      chk($sformatf("bp_valid_s%0d", s), oValid, 1);
      chk($sformatf("bp_ct_s%0d", s), oBlockOut, vecs[0].ct);
      chk($sformatf("bp_ready_s%0d", s), oReady, 0);
      iValid = 1'b1;
      iBlockIn = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    iValid = 1'b0;
    iReady = 1'b1;
    chk("bp_valid_release", oValid, 1);
    tick();
    iReady = 1'b0;
    chk("bp_idle_ready", oReady, 1);
    chk("bp_idle_valid", oValid, 0);
    chk("bp_idle_busy", oBusy, 0);
    tick();
    chk("bp_no_accept", oBusy, 0);

    // Back-to-back with iValid held high.
    bB = {$urandom, $urandom, $urandom, $urandom};
    iBlockIn = vecs[0].pt;
    iValid = 1'b1;
    iReady = 1'b1;
    tick();
    iBlockIn = bB;
    repeat (30) tick();
    chk("b2b_a_valid", oValid, 1);
    chk("b2b_a_ct", oBlockOut, vecs[0].ct);
    tick();
    chk("b2b_second_accept", oReady, 1);
    tick();
    iValid = 1'b0;
    chk("b2b_b_busy", oBusy, 1);
    repeat (30) tick();
    chk("b2b_b_valid", oValid, 1);
    chk("b2b_b_ct", oBlockOut, aesEncrypt(vecs[0].key, bB));
    tick();
    iReady = 1'b0;
    chk("b2b_b_release", oReady, 1);

    // Reset mid-operation at cycle 12.
    loadKey(vecs[1].key);
    iBlockIn = vecs[1].pt;
    iValid = 1'b1;
    tick();
    iValid = 1'b0;
    repeat (11) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chkReset("midrst");
    sawValid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (oValid) sawValid = 1'b1;
      tick();
    end
    chk("midrst_no_valid", sawValid, 0);
    pR = {$urandom, $urandom, $urandom, $urandom};
    runBlock(vecs[1].key, pR);

    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      runBlock({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
